// File: rtl/vec_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : vec_addsub
//  Purpose  : Element-wise signed vector add/subtract. Pops operand vectors
//             from an upstream FWFT FIFO, computes all elements in parallel
//             into one stage register, then queues the results in a small
//             first-word-fall-through output buffer.
//  Ports    : clock      - rising-edge clock
//             reset      - asynchronous, active-low reset
//             x, y       - operand vectors at the upstream FIFO head
//             op         - 0: x+y, 1: x-y (travels with the head word)
//             in_empty   - upstream FIFO holds no vector
//             in_rd_en   - pops the upstream head
//             out        - output buffer head (zero while empty)
//             out_ovf    - per-element overflow flags of the head
//             out_empty  - output buffer holds no vector
//             out_rd_en  - pops the output buffer head
//             out_count  - vectors held in the output buffer
//  Revision : 1.0 - initial release
// ============================================================================
module vec_addsub #(
   parameter int DATA_WIDTH = 32,
   parameter int ARRAY_SIZE = 3,
   parameter int OUT_DEPTH  = 4,   // power of two, >= 2
   parameter int SATURATE   = 0
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] x,
   input  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] y,
   input  logic                                        op,
   input  logic                                        in_empty,
   output logic                                        in_rd_en,
   output logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] out,
   output logic        [ARRAY_SIZE-1:0]                out_ovf,
   output logic                                        out_empty,
   input  logic                                        out_rd_en,
   output logic        [$clog2(OUT_DEPTH):0]           out_count
);

   localparam int c_ptr_w = $clog2(OUT_DEPTH);
   localparam logic [c_ptr_w-1:0] c_ptr_one = 1;
   localparam logic [c_ptr_w:0]   c_cnt_one = 1;
   localparam logic [c_ptr_w+1:0] c_depth   = (c_ptr_w+2)'(OUT_DEPTH);
   localparam logic [DATA_WIDTH-1:0] c_max  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] c_min  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

   // ------------------------------------------------------------------------
   // Reset release synchroniser: the pop path stays idle until the
   // de-assertion of reset has been seen on two clock edges.
   // ------------------------------------------------------------------------
   logic [1:0] r_rst_sync;
   logic       w_run;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_run = r_rst_sync[1];

   // ------------------------------------------------------------------------
   // Element arithmetic at DATA_WIDTH+1 bits; overflow when the two top bits
   // of the widened result disagree.
   // ------------------------------------------------------------------------
   vec_t                  w_result;
   logic [ARRAY_SIZE-1:0] w_ovf;

   genvar gi;
   generate
      for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_elem
         logic [DATA_WIDTH:0]   w_wide;
         logic [DATA_WIDTH-1:0] w_res;

         always_comb begin
            if (op) w_wide = {x[gi][DATA_WIDTH-1], x[gi]} - {y[gi][DATA_WIDTH-1], y[gi]};
            else    w_wide = {x[gi][DATA_WIDTH-1], x[gi]} + {y[gi][DATA_WIDTH-1], y[gi]};
         end

         assign w_ovf[gi] = w_wide[DATA_WIDTH] ^ w_wide[DATA_WIDTH-1];

         // The true sign of an overflowed result is the top (extra) bit.
         always_comb begin
            w_res = w_wide[DATA_WIDTH-1:0];
            if ((SATURATE != 0) && w_ovf[gi])
               w_res = w_wide[DATA_WIDTH] ? c_min : c_max;
         end

         assign w_result[gi] = w_res;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Credit check: the stage register counts against buffer space so a
   // popped vector always has a slot waiting for it.
   // ------------------------------------------------------------------------
   logic                  r_stage_valid;
   vec_t                  r_stage_data;
   logic [ARRAY_SIZE-1:0] r_stage_ovf;
   logic [c_ptr_w:0]      r_count;
   logic [c_ptr_w+1:0]    w_used;

   assign w_used   = {1'b0, r_count} + {{(c_ptr_w+1){1'b0}}, r_stage_valid};
   assign in_rd_en = w_run && !in_empty && (w_used < c_depth);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stage_valid <= 1'b0;
         r_stage_data  <= '0;
         r_stage_ovf   <= '0;
      end else begin
         r_stage_valid <= in_rd_en;
         if (in_rd_en) begin
            r_stage_data <= w_result;
            r_stage_ovf  <= w_ovf;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output buffer. Pointers wrap naturally because OUT_DEPTH is a power of
   // two. Reads while empty are masked so they never move the read pointer.
   // ------------------------------------------------------------------------
   vec_t                  r_mem_data [OUT_DEPTH];
   logic [ARRAY_SIZE-1:0] r_mem_ovf  [OUT_DEPTH];
   logic [c_ptr_w-1:0]    r_wr_ptr;
   logic [c_ptr_w-1:0]    r_rd_ptr;
   logic                  w_wr;
   logic                  w_rd;

   assign w_wr = r_stage_valid;
   assign w_rd = out_rd_en && (r_count != '0);

   always_ff @(posedge clock) begin
      if (w_wr) begin
         r_mem_data[r_wr_ptr] <= r_stage_data;
         r_mem_ovf[r_wr_ptr]  <= r_stage_ovf;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_rd) r_rd_ptr <= r_rd_ptr + c_ptr_one;
         if (w_wr && !w_rd)      r_count <= r_count + c_cnt_one;
         else if (!w_wr && w_rd) r_count <= r_count - c_cnt_one;
      end
   end

   // Memory is not reset, so the head is masked to zero while empty.
   assign out_empty = (r_count == '0);
   assign out_count = r_count;
   assign out       = out_empty ? '0 : r_mem_data[r_rd_ptr];
   assign out_ovf   = out_empty ? '0 : r_mem_ovf[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_vec_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vec_addsub
//  Purpose  : Self-checking bench for vec_addsub. Two instances (wrap and
//             saturate) share one upstream FIFO model and one reader; every
//             cycle both are compared against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vec_addsub;

   localparam int W = 32;
   localparam int N = 3;
   localparam int D = 4;
   localparam longint MAXV = (longint'(1) << (W-1)) - 1;
   localparam longint MINV = -(longint'(1) << (W-1));

   typedef logic [N-1:0][W-1:0] vec_t;
   typedef struct { vec_t x; vec_t y; bit op; } in_t;
   typedef struct { vec_t wrap; vec_t sat; logic [N-1:0] ovf; } res_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic op = 1'b0;
   logic in_empty = 1'b1;
   logic out_rd_en = 1'b0;
   vec_t x = '0;
   vec_t y = '0;

   logic          in_rd_en0, in_rd_en1, out_empty0, out_empty1;
   vec_t          out0, out1;
   logic [N-1:0]  ovf0, ovf1;
   logic [2:0]    cnt0, cnt1;

   vec_addsub #(.DATA_WIDTH(W), .ARRAY_SIZE(N), .OUT_DEPTH(D), .SATURATE(0)) dut_wrap (
      .clock(clock), .reset(reset), .x(x), .y(y), .op(op), .in_empty(in_empty),
      .in_rd_en(in_rd_en0), .out(out0), .out_ovf(ovf0), .out_empty(out_empty0),
      .out_rd_en(out_rd_en), .out_count(cnt0));

   vec_addsub #(.DATA_WIDTH(W), .ARRAY_SIZE(N), .OUT_DEPTH(D), .SATURATE(1)) dut_sat (
      .clock(clock), .reset(reset), .x(x), .y(y), .op(op), .in_empty(in_empty),
      .in_rd_en(in_rd_en1), .out(out1), .out_ovf(ovf1), .out_empty(out_empty1),
      .out_rd_en(out_rd_en), .out_count(cnt1));

   always #5 clock = ~clock;

   in_t  src_q[$];
   res_t m_buf[$];
   res_t m_stage;
   bit   m_stage_valid = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   release_edges = 0;
   int   n_cycles = 0;
   int   n_pops = 0;
   int   n_reads = 0;
   int   pop_edge = -1;

   // Reference arithmetic with plain 64-bit integers.
   function automatic res_t model(input in_t v);
      res_t   r;
      longint a, b, s;
      for (int i = 0; i < N; i++) begin
         a = longint'($signed(v.x[i]));
         b = longint'($signed(v.y[i]));
         s = v.op ? a - b : a + b;
         r.ovf[i]  = (s > MAXV) || (s < MINV);
         r.wrap[i] = W'(s);
         r.sat[i]  = W'((s > MAXV) ? MAXV : ((s < MINV) ? MINV : s));
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_elem();
      case ($urandom_range(0, 5))
         0:       return 32'h7FFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return W'($urandom_range(0, 3));
         3:       return 32'hFFFF_FFFF;
         default: return W'($urandom);
      endcase
   endfunction

   task automatic drive_head();
      if (src_q.size() != 0) begin
         x = src_q[0].x; y = src_q[0].y; op = src_q[0].op; in_empty = 1'b0;
      end else begin
         x = '0; y = '0; op = 1'b0; in_empty = 1'b1;
      end
   endtask

   task automatic push_rand(input int n);
      in_t v;
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < N; i++) begin
            v.x[i] = rand_elem();
            v.y[i] = rand_elem();
         end
         v.op = 1'($urandom_range(0, 1));
         src_q.push_back(v);
      end
      drive_head();
   endtask

   // One clock cycle: sample at the falling edge, compare with the model,
   // then advance the model across the rising edge.
   task automatic tick();
      bit pop, rd, allowed;
      int occ;
      @(negedge clock);
      pop = in_rd_en0;
      rd  = out_rd_en && !out_empty0;
      occ = m_buf.size() + int'(m_stage_valid);
      allowed = reset && (src_q.size() != 0) && (occ < D) && (release_edges >= 1);
      n_tests++;
      if ((in_rd_en0 || in_rd_en1) && !allowed) begin
         n_fail++;
         $display("FAIL in_rd_en_credit: got %b/%b required 0 (occupancy %0d)", in_rd_en0, in_rd_en1, occ);
      end
      if (allowed && release_edges >= 3) begin
         n_tests++;
         if (!in_rd_en0 || !in_rd_en1) begin
            n_fail++;
            $display("FAIL in_rd_en_stall: got %b/%b required 1", in_rd_en0, in_rd_en1);
         end
      end
      n_tests++;
      if (cnt0 !== 3'(m_buf.size()) || cnt1 !== 3'(m_buf.size()) ||
          out_empty0 !== (m_buf.size() == 0) || out_empty1 !== (m_buf.size() == 0)) begin
         n_fail++;
         $display("FAIL occupancy: got count %0d/%0d empty %b/%b required count %0d",
                  cnt0, cnt1, out_empty0, out_empty1, m_buf.size());
      end
      if (m_buf.size() != 0) begin
         n_tests++;
         if (out0 !== m_buf[0].wrap || ovf0 !== m_buf[0].ovf) begin
            n_fail++;
            $display("FAIL head_wrap: got %h ovf %b required %h ovf %b", out0, ovf0, m_buf[0].wrap, m_buf[0].ovf);
         end
         n_tests++;
         if (out1 !== m_buf[0].sat || ovf1 !== m_buf[0].ovf) begin
            n_fail++;
            $display("FAIL head_sat: got %h ovf %b required %h ovf %b", out1, ovf1, m_buf[0].sat, m_buf[0].ovf);
         end
      end
      @(posedge clock);
      #1;
      n_cycles++;
      if (reset && release_edges < 100) release_edges++;
      if (rd && m_buf.size() != 0) begin
         void'(m_buf.pop_front());
         n_reads++;
      end
      if (m_stage_valid) m_buf.push_back(m_stage);
      m_stage_valid = pop;
      if (pop && src_q.size() != 0) begin
         m_stage = model(src_q[0]);
         void'(src_q.pop_front());
         n_pops++;
         pop_edge = n_cycles;
      end
      drive_head();
   endtask

   task automatic drain();
      int guard = 0;
      out_rd_en = 1'b1;
      while ((src_q.size() != 0 || m_buf.size() != 0 || m_stage_valid || !out_empty0) && guard < 5000) begin
         tick();
         guard++;
      end
      n_tests++;
      if (guard >= 5000) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d cycles required < 5000", guard);
      end
      out_rd_en = 1'b0;
   endtask

   task automatic test_reset();
      push_rand(1);
      #2;
      n_tests++;
      if (in_rd_en0 !== 1'b0 || in_rd_en1 !== 1'b0 || out_empty0 !== 1'b1 || cnt0 !== 3'd0 ||
          out0 !== '0 || ovf0 !== '0 || out1 !== '0 || ovf1 !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got rd %b empty %b count %0d out %h ovf %b required 0 1 0 0 0",
                  in_rd_en0, out_empty0, cnt0, out0, ovf0);
      end
      tick();
      tick();
      reset = 1'b1;
      release_edges = 0;
      #1;
      n_tests++;
      if (in_rd_en0 !== 1'b0) begin
         n_fail++;
         $display("FAIL release_rd_en: got %b required 0", in_rd_en0);
      end
      drain();
   endtask

   task automatic test_directed();
      in_t v;
      int  lat, guard;
      v.x[0] = 32'd5; v.x[1] = 32'hFFFF_FFFD; v.x[2] = 32'h7FFF_FFFF;
      v.y[0] = 32'd2; v.y[1] = 32'd4;         v.y[2] = 32'd1;
      v.op = 1'b1;
      src_q.push_back(v);
      drive_head();
      pop_edge = -1;
      guard = 0;
      do begin
         tick();
         guard++;
      end while (out_empty0 && guard < 10);
      lat = n_cycles - pop_edge + 1;
      n_tests++;
      if (pop_edge < 0 || lat != 2) begin
         n_fail++;
         $display("FAIL directed_latency: got %0d edges required 2", lat);
      end
      n_tests++;
      if (out0 !== {32'h7FFF_FFFE, 32'hFFFF_FFF9, 32'd3} || ovf0 !== 3'b000 ||
          out1 !== {32'h7FFF_FFFE, 32'hFFFF_FFF9, 32'd3}) begin
         n_fail++;
         $display("FAIL directed_value: got %h ovf %b required 7ffffffefffffff900000003 ovf 000", out0, ovf0);
      end
      drain();
   endtask

   task automatic test_overflow();
      in_t a, b;
      int  guard = 0;
      a.x[0] = 32'h7FFF_FFFF; a.x[1] = 32'd10; a.x[2] = 32'hFFFF_FFFB;
      a.y[0] = 32'd1;         a.y[1] = 32'd20; a.y[2] = 32'hFFFF_FFFB;
      a.op = 1'b0;
      b.x[0] = 32'h8000_0000; b.x[1] = 32'h8000_0000; b.x[2] = 32'd0;
      b.y[0] = 32'd1;         b.y[1] = 32'hFFFF_FFFF; b.y[2] = 32'h8000_0000;
      b.op = 1'b1;
      src_q.push_back(a);
      src_q.push_back(b);
      drive_head();
      while (cnt0 != 3'd2 && guard < 10) begin
         tick();
         guard++;
      end
      n_tests++;
      if (out0 !== {32'hFFFF_FFF6, 32'd30, 32'h8000_0000} || ovf0 !== 3'b001) begin
         n_fail++;
         $display("FAIL ovf_pos_wrap: got %h ovf %b required fffffff60000001e80000000 ovf 001", out0, ovf0);
      end
      n_tests++;
      if (out1 !== {32'hFFFF_FFF6, 32'd30, 32'h7FFF_FFFF} || ovf1 !== 3'b001) begin
         n_fail++;
         $display("FAIL ovf_pos_sat: got %h ovf %b required fffffff60000001e7fffffff ovf 001", out1, ovf1);
      end
      out_rd_en = 1'b1;
      tick();
      out_rd_en = 1'b0;
      n_tests++;
      if (out0 !== {32'h8000_0000, 32'h8000_0001, 32'h7FFF_FFFF} || ovf0 !== 3'b101) begin
         n_fail++;
         $display("FAIL ovf_neg_wrap: got %h ovf %b required 80000000800000017fffffff ovf 101", out0, ovf0);
      end
      n_tests++;
      if (out1 !== {32'h7FFF_FFFF, 32'h8000_0001, 32'h8000_0000} || ovf1 !== 3'b101) begin
         n_fail++;
         $display("FAIL ovf_neg_sat: got %h ovf %b required 7fffffff8000000180000000 ovf 101", out1, ovf1);
      end
      drain();
   endtask

   task automatic test_backpressure();
      int reads0;
      out_rd_en = 1'b0;
      push_rand(1000);
      for (int k = 0; k < 12; k++) tick();
      n_tests++;
      if (cnt0 !== 3'd4 || cnt1 !== 3'd4 || in_rd_en0 !== 1'b0) begin
         n_fail++;
         $display("FAIL backpressure_full: got count %0d/%0d rd_en %b required 4/4 0", cnt0, cnt1, in_rd_en0);
      end
      reads0 = n_reads;
      drain();
      n_tests++;
      if (n_reads - reads0 != 1000) begin
         n_fail++;
         $display("FAIL backpressure_total: got %0d vectors required 1000", n_reads - reads0);
      end
   endtask

   task automatic test_back_to_back();
      int pops0, bad_cnt, stalls;
      pops0 = n_pops; bad_cnt = 0; stalls = 0;
      push_rand(200);
      out_rd_en = 1'b1;
      for (int k = 0; k < 215; k++) begin
         tick();
         if (k >= 3) begin
            if (cnt0 > 3'd1) bad_cnt++;
            if (src_q.size() != 0 && !in_rd_en0) stalls++;
         end
      end
      n_tests++;
      if (bad_cnt != 0) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d cycles with count>1 required 0", bad_cnt);
      end
      n_tests++;
      if (stalls != 0) begin
         n_fail++;
         $display("FAIL b2b_throughput: got %0d stall cycles required 0", stalls);
      end
      n_tests++;
      if (n_pops - pops0 != 200) begin
         n_fail++;
         $display("FAIL b2b_pops: got %0d required 200", n_pops - pops0);
      end
      drain();
   endtask

   task automatic test_reset_midstream();
      int guard = 0;
      out_rd_en = 1'b0;
      push_rand(20);
      while (m_buf.size() != 3 && guard < 20) begin
         tick();
         guard++;
      end
      n_tests++;
      if (cnt0 !== 3'd3) begin
         n_fail++;
         $display("FAIL midreset_setup: got count %0d required 3", cnt0);
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if (cnt0 !== 3'd0 || cnt1 !== 3'd0 || out_empty0 !== 1'b1 || out_empty1 !== 1'b1 ||
          out0 !== '0 || out1 !== '0 || ovf0 !== '0 || ovf1 !== '0 || in_rd_en0 !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_clear: got count %0d empty %b out %h ovf %b rd %b required 0 1 0 0 0",
                  cnt0, out_empty0, out0, ovf0, in_rd_en0);
      end
      m_buf.delete();
      m_stage_valid = 1'b0;
      tick();
      reset = 1'b1;
      release_edges = 0;
      drain();
   endtask

   task automatic test_empty_read();
      res_t exp;
      int   guard = 0;
      out_rd_en = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      n_tests++;
      if (cnt0 !== 3'd0 || out_empty0 !== 1'b1) begin
         n_fail++;
         $display("FAIL empty_read_count: got %0d empty %b required 0 1", cnt0, out_empty0);
      end
      out_rd_en = 1'b0;
      push_rand(1);
      exp = model(src_q[0]);
      while (out_empty0 && guard < 6) begin
         tick();
         guard++;
      end
      n_tests++;
      if (out0 !== exp.wrap || ovf0 !== exp.ovf || out1 !== exp.sat || cnt0 !== 3'd1) begin
         n_fail++;
         $display("FAIL empty_read_next: got %h ovf %b count %0d required %h ovf %b count 1",
                  out0, ovf0, cnt0, exp.wrap, exp.ovf);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_overflow();
      test_backpressure();
      test_back_to_back();
      test_reset_midstream();
      test_empty_read();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation time limit required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/vec_addsub.md
VEC_ADDSUB -- requirements
Module: vec_addsub

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the signed element width in bits.
REQ-002 The block SHALL have parameter ARRAY_SIZE, default 3, giving the elements per vector.
REQ-003 The block SHALL have parameter OUT_DEPTH, default 4, giving the output buffer depth in vectors; it SHALL be a power of two, at least 2.
REQ-004 The block SHALL have parameter SATURATE, default 0: 0 = wrap-around arithmetic, 1 = clamp to the signed range.
REQ-005 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port x, input, ARRAY_SIZE x DATA_WIDTH signed: first operand vector from the upstream FIFO head.
REQ-008 The block SHALL have port y, input, ARRAY_SIZE x DATA_WIDTH signed: second operand vector from the upstream FIFO head.
REQ-009 The block SHALL have port op, input, 1 bit: 0 = x+y, 1 = x-y; it travels with the x/y head word.
REQ-010 The block SHALL have port in_empty, input, 1 bit: the upstream FIFO holds no vector.
REQ-011 The block SHALL have port in_rd_en, output, 1 bit: pops the upstream head.
REQ-012 The block SHALL have port out, output, ARRAY_SIZE x DATA_WIDTH signed: output buffer head.
REQ-013 The block SHALL have port out_ovf, output, ARRAY_SIZE bits: per-element overflow flag of the head.
REQ-014 The block SHALL have port out_empty, output, 1 bit: output buffer holds no vector.
REQ-015 The block SHALL have port out_rd_en, input, 1 bit: pops the output buffer head.
REQ-016 The block SHALL have port out_count, output, clog2(OUT_DEPTH)+1 bits: vectors held in the output buffer.

Function
REQ-017 The block SHALL drive in_rd_en combinationally, high iff !in_empty and (out_count + stage_valid) < OUT_DEPTH; this credit check SHALL guarantee the buffer never overflows.
REQ-018 On a rising edge with in_rd_en=1, the block SHALL compute all ARRAY_SIZE element results in parallel from x, y and op and register them into a single stage register with stage_valid=1.
REQ-019 A valid stage SHALL write into the output buffer on the next edge, giving latency = 2 edges from the in_rd_en edge to out_empty falling.
REQ-020 Throughput SHALL be one vector per cycle when the upstream FIFO is non-empty and the downstream side reads every cycle.
REQ-021 Each element SHALL be computed at DATA_WIDTH+1 bits; overflow exists iff the two top bits of the wide result differ.
REQ-022 With SATURATE=0 the result SHALL be the low DATA_WIDTH bits (mod 2^DATA_WIDTH); with SATURATE=1 positive overflow SHALL clamp to 2^(W-1)-1 and negative overflow to -2^(W-1).
REQ-023 out_ovf[i] SHALL be 1 iff element i overflowed, in both modes.
REQ-024 The output buffer SHALL be first-word-fall-through: out and out_ovf are valid whenever out_empty=0.
REQ-025 The output buffer read/write pointers SHALL wrap modulo OUT_DEPTH.
REQ-026 out_rd_en while out_empty=1 SHALL be ignored, with no pointer or count change.
REQ-027 A simultaneous buffer write and read SHALL leave out_count unchanged; this SHALL be legal when the buffer is full, since the credit check has already reserved space.
REQ-028 Ordering SHALL be strict FIFO; no vector SHALL be dropped or duplicated.

Reset
REQ-029 While reset=0 the block SHALL immediately clear stage_valid and the buffer pointers, with out_count=0, out_empty=1, out_ovf=0, out=0 and in_rd_en=0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight and buffered vectors; the first vector after release SHALL follow REQ-019 latency.
REQ-031 Reset release SHALL be synchronised to clock; in_rd_en SHALL not assert before the first edge after release.

Verification
REQ-032 Scenario: W=32, SATURATE=0, vector x=(5,-3,0x7FFFFFFF), y=(2,4,1), op=1 -> out=(3,-7,0x7FFFFFFE), out_ovf=000, out_empty low 2 edges after pop.
REQ-033 Scenario: x=0x7FFFFFFF, y=1, op=0 -> SATURATE=0 gives 0x80000000 with ovf=1; SATURATE=1 gives 0x7FFFFFFF with ovf=1; x=0x80000000, y=1, op=1 with SATURATE=1 gives 0x80000000 with ovf=1.
REQ-034 Scenario: stream 1000 random vectors with out_rd_en held 0 -> in_rd_en stops with out_count=OUT_DEPTH=4; then read continuously -> all 1000 vectors match the model in order, no loss.
REQ-035 Scenario: continuous input with out_rd_en=1 every cycle -> one vector per cycle, out_count stays at 1 or less after fill, and pointers wrap at least 3 times.
REQ-036 Scenario: reset pulsed low mid-stream while out_count=3 -> outputs cleared immediately; later vectors correct with no stale data.
REQ-037 Scenario: out_rd_en pulsed while out_empty=1 -> out_count stays 0 and the next written vector is read intact.
